// File: rtl/capck_gate_ctrl.sv
// Per-channel clock-gate enable controller with request/acknowledge handshake,
// programmable on/off settling delays, scan override and a breadboard master enable.
module capck_gate_ctrl #(
  parameter int unsigned     NCH        = 6,
  parameter int unsigned     CNTW       = 4,
  parameter int unsigned     ON_DLY     = 3,
  parameter int unsigned     OFF_DLY    = 2,
  parameter logic [NCH-1:0]  FORCE_MASK = NCH'(1)
) (
  input  logic           clk_fclk,
  input  logic           resb,
  input  logic           capmx_bbmode,
  input  logic           mod_scanmode,
  input  logic [NCH-1:0] ch_req,
  output logic [NCH-1:0] ch_ack,
  output logic [NCH-1:0] gate_en,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON_WAIT  = 2'd1,
    ST_ON       = 2'd2,
    ST_OFF_WAIT = 2'd3
  } state_e;

  // Load values are clamped to 1 so a WAIT state can never count through zero.
  localparam logic [CNTW-1:0] ON_LOAD  = (ON_DLY  == 0) ? CNTW'(1) : CNTW'(ON_DLY);
  localparam logic [CNTW-1:0] OFF_LOAD = (OFF_DLY == 0) ? CNTW'(1) : CNTW'(OFF_DLY);

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [CNTW-1:0] cnt_q   [NCH];
  logic [CNTW-1:0] cnt_d   [NCH];

  logic [NCH-1:0]  eff;
  logic [NCH-1:0]  gate_q, gate_d;
  logic            busy_q, busy_d;

  assign eff = ch_req & {NCH{capmx_bbmode}};

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path leaves a latch.
    gate_d = '0;
    busy_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_OFF: begin
          if (eff[i]) begin
            if (ON_DLY == 0) begin
              state_d[i] = ST_ON;
            end else begin
              state_d[i] = ST_ON_WAIT;
              cnt_d[i]   = ON_LOAD;
            end
          end
        end
        ST_ON_WAIT: begin
          if (!eff[i]) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] <= CNTW'(1)) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] - CNTW'(1);
          end
        end
        ST_ON: begin
          if (!eff[i]) begin
            if (OFF_DLY == 0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_OFF_WAIT;
              cnt_d[i]   = OFF_LOAD;
            end
          end
        end
        ST_OFF_WAIT: begin
          // A returning request re-opens immediately; the gate never dropped.
          if (eff[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] <= CNTW'(1)) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] - CNTW'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase

      gate_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_OFF_WAIT);
      if ((state_d[i] == ST_ON_WAIT) || (state_d[i] == ST_OFF_WAIT)) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fclk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resb) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      gate_q <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gate_q <= gate_d;
      busy_q <= busy_d;
    end
  end

  // Scan override is the only combinational path to the gate cells.
  assign gate_en = gate_q | (FORCE_MASK & {NCH{mod_scanmode}});
  assign ch_ack  = gate_q;
  assign busy    = busy_q;

endmodule
